psum_accum: RTL and testbench

Downstream consumer of the 11-lane FP32 dot-product stage. It takes the stream of `mac_done`/`mac_data` partial sums, reduces every group of `NUM_TERMS` consecutive results into one FP32 value, adds a per-group bias, optionally applies ReLU, and presents the result on a ready/valid output. The dot-product stage has no backpressure, so the block buffers inputs in a FIFO and reports almost-full so the upstream controller can throttle `mac_req`.

---
 rtl/psum_pkg.sv | 17 +
 rtl/add.sv | 105 ++++++++++
 rtl/psum_fifo.sv | 51 +++++
 rtl/psum_accum.sv | 163 ++++++++++++++++
 tb/tb_psum_accum.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// Shared types and constants for the partial-sum accumulator.
// Imported by the accumulator top and its FIFO.
package psum_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    WAIT,
    BIAS,
    BWAIT,
    OUT
  } psum_state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam int          FP32_SIGN = 31;

endpackage

// File: rtl/add.sv
// FP32 AXI-Stream adder core: fixed-latency pipeline, round-to-nearest-even,
// denormals flushed to zero, NaN/Inf propagated. LATENCY must be at least 2.
module add #(
  parameter int LATENCY = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready,
  output logic [31:0] m_axis_result_tdata
);

  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        ex, ey, d;
    logic [26:0]       mx, my, shifted, norm;
    logic [27:0]       sum;
    logic              sticky;
    int                lz;
    logic signed [9:0] e;
    logic [24:0]       rnd;
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
      return 32'h7FC0_0000;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    // x always carries the larger magnitude, so it also sets the result sign
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 8'd0) return 32'h0000_0000;
    mx = {1'b1, x[22:0], 3'b000};
    my = (ey == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d  = ex - ey;
    if (d >= 8'd27) begin
      shifted = 27'd0;
      sticky  = |my;
    end else begin
      shifted = my >> d;
      sticky  = |(my & ((27'd1 << d) - 27'd1));
    end
    shifted[0] = shifted[0] | sticky;
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, shifted};
    else                sum = {1'b0, mx} - {1'b0, shifted};
    if (sum == 28'd0) return 32'h0000_0000;
    e = {2'b00, ex};
    if (sum[27]) begin
      norm    = sum[27:1];
      norm[0] = norm[0] | sum[0];
      e       = e + 10'sd1;
    end else begin
      lz = 0;
      for (int i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
      norm = sum[26:0] << lz;
      e    = e - 10'(lz);
    end
    rnd = {1'b0, norm[26:3]} + 25'(norm[2] & (norm[1] | norm[0] | norm[3]));
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'sd1;
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0)   return 32'h0000_0000;
    return {x[31], e[7:0], rnd[22:0]};
  endfunction

  logic [LATENCY-1:0] vld_pipe;
  logic [31:0]        data_pipe [LATENCY];
  logic               advance;
  logic               fire;

  assign advance         = m_axis_result_tready || !vld_pipe[LATENCY-1];
  assign s_axis_a_tready = advance;
  assign s_axis_b_tready = advance;
  assign fire            = s_axis_a_tvalid && s_axis_b_tvalid && advance;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[LATENCY-2:0], fire};
  end

  always_ff @(posedge aclk) begin
    if (advance) begin
      data_pipe[0] <= fp32_add(s_axis_a_tdata, s_axis_b_tdata);
      for (int i = 1; i < LATENCY; i++) data_pipe[i] <= data_pipe[i-1];
    end
  end

  assign m_axis_result_tvalid = vld_pipe[LATENCY-1];
  assign m_axis_result_tdata  = data_pipe[LATENCY-1];

endmodule

// File: rtl/psum_fifo.sv
// Synchronous input FIFO with full/empty and a registered almost-full flag.
// A pop in the same cycle as a write while full makes room for that write.
module psum_fifo #(
  parameter int DEPTH  = 16,
  parameter int MARGIN = 4,
  parameter int WIDTH  = 32
) (
  input  logic             aclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             afull
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LEVEL = (AW+1)'(DEPTH - MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             do_rd, do_wr;

  // The extra pointer MSB distinguishes full from empty when the indices match
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_LEVEL);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      afull  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      afull <= (count >= AFULL_LEVEL);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/psum_accum.sv
// Reduces groups of NUM_TERMS FP32 partial sums, adds a per-group bias and
// optional ReLU, and presents each result on a ready/valid output.
module psum_accum
  import psum_pkg::*;
#(
  parameter int NUM_TERMS    = 11,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic        aclk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  logic [31:0] in_data,
  output logic        in_afull,
  input  logic [31:0] bias,
  input  logic        relu_en,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_data,
  output logic        ovf_err
);

  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_TERMS);

  psum_state_t   state, state_next;
  logic [31:0]   acc, bias_r;
  logic          relu_r;
  logic [CW-1:0] cnt, cnt_inc;

  logic          fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [31:0]   fifo_head;

  logic          add_a_vld, add_b_vld, add_a_rdy, add_b_rdy, res_vld;
  logic [31:0]   add_a, add_b, res_data;

  logic          load_first, acc_wr, out_load, out_clear;

  assign cnt_inc   = cnt + 1'b1;
  assign fifo_drop = in_vld && fifo_full && !fifo_pop;

  psum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .MARGIN(AFULL_MARGIN),
    .WIDTH (32)
  ) u_fifo (
    .aclk   (aclk),
    .rst_n  (rst_n),
    .wr_en  (in_vld),
    .wr_data(in_data),
    .rd_en  (fifo_pop),
    .rd_data(fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .afull  (in_afull)
  );

  add u_add (
    .aclk                (aclk),
    .aresetn             (rst_n),
    .s_axis_a_tvalid     (add_a_vld),
    .s_axis_a_tready     (add_a_rdy),
    .s_axis_a_tdata      (add_a),
    .s_axis_b_tvalid     (add_b_vld),
    .s_axis_b_tready     (add_b_rdy),
    .s_axis_b_tdata      (add_b),
    .m_axis_result_tvalid(res_vld),
    .m_axis_result_tready(1'b1),
    .m_axis_result_tdata (res_data)
  );

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Only one add is ever in flight: every issue state is followed by a wait state
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    load_first = 1'b0;
    acc_wr     = 1'b0;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    add_a_vld  = 1'b0;
    add_b_vld  = 1'b0;
    add_a      = acc;
    add_b      = fifo_head;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_first = 1'b1;
          state_next = (NUM_TERMS > 1) ? ACC : BIAS;
        end
      end
      ACC: begin
        add_a_vld = !fifo_empty;
        add_b_vld = !fifo_empty;
        if (!fifo_empty && add_a_rdy && add_b_rdy) begin
          fifo_pop   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (res_vld) begin
          acc_wr     = 1'b1;
          state_next = (cnt_inc == CNT_LAST) ? BIAS : ACC;
        end
      end
      BIAS: begin
        add_b     = bias_r;
        add_a_vld = 1'b1;
        add_b_vld = 1'b1;
        if (add_a_rdy && add_b_rdy) state_next = BWAIT;
      end
      BWAIT: begin
        if (res_vld) begin
          out_load   = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_rdy) begin
          out_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= FP32_ZERO;
      cnt      <= '0;
      bias_r   <= FP32_ZERO;
      relu_r   <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= FP32_ZERO;
      ovf_err  <= 1'b0;
    end else begin
      if (load_first) begin
        acc    <= fifo_head;
        cnt    <= CW'(1);
        bias_r <= bias;
        relu_r <= relu_en;
      end
      if (acc_wr) begin
        acc <= res_data;
        cnt <= cnt_inc;
      end
      // ReLU keys on the sign bit alone, so -0.0 also becomes +0.0
      if (out_load) begin
        out_vld  <= 1'b1;
        out_data <= (relu_r && res_data[FP32_SIGN]) ? FP32_ZERO : res_data;
      end
      if (out_clear) out_vld <= 1'b0;
      if (fifo_drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Self-checking bench for psum_accum: directed groups plus random groups
// checked against a real-arithmetic reference of sum + bias and ReLU.
module tb_psum_accum;

  logic        aclk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [31:0] bias;
  logic        relu_en;
  logic [2:0]  vld, rdy, ovld, afull, ovf;
  logic [31:0] odata [3];

  int compares = 0;
  int fails    = 0;

  always #5 aclk = ~aclk;

  // Instance 0: main, 1: small FIFO for overflow, 2: single-term groups
  psum_accum #(.NUM_TERMS(3), .FIFO_DEPTH(16), .AFULL_MARGIN(4)) u_main (
    .aclk(aclk), .rst_n(rst_n), .in_vld(vld[0]), .in_data(in_data), .in_afull(afull[0]),
    .bias(bias), .relu_en(relu_en), .out_vld(ovld[0]), .out_rdy(rdy[0]),
    .out_data(odata[0]), .ovf_err(ovf[0]));

  psum_accum #(.NUM_TERMS(3), .FIFO_DEPTH(4), .AFULL_MARGIN(1)) u_ovf (
    .aclk(aclk), .rst_n(rst_n), .in_vld(vld[1]), .in_data(in_data), .in_afull(afull[1]),
    .bias(bias), .relu_en(relu_en), .out_vld(ovld[1]), .out_rdy(rdy[1]),
    .out_data(odata[1]), .ovf_err(ovf[1]));

  psum_accum #(.NUM_TERMS(1), .FIFO_DEPTH(16), .AFULL_MARGIN(4)) u_one (
    .aclk(aclk), .rst_n(rst_n), .in_vld(vld[2]), .in_data(in_data), .in_afull(afull[2]),
    .bias(bias), .relu_en(relu_en), .out_vld(ovld[2]), .out_rdy(rdy[2]),
    .out_data(odata[2]), .ovf_err(ovf[2]));

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0000_0000;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] model(input real sum, input logic relu);
    if (relu && sum < 0.0) return 32'h0000_0000;
    return to_fp32(sum);
  endfunction

  function automatic real rand_half();
    return (real'($urandom_range(0, 80)) - 40.0) * 0.5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send(input int inst, input logic [31:0] word);
    vld[inst] = 1'b1;
    in_data   = word;
    tick(1);
    vld[inst] = 1'b0;
  endtask

  task automatic wait_out(input int inst, input string tag);
    int budget = 400;
    while (!ovld[inst] && budget > 0) begin
      tick(1);
      budget--;
    end
    check({tag, " out_vld"}, {31'd0, ovld[inst]}, 32'd1);
  endtask

  task automatic take(input int inst, input string tag, input logic [31:0] exp);
    wait_out(inst, tag);
    check({tag, " data"}, odata[inst], exp);
    rdy[inst] = 1'b1;
    tick(1);
    rdy[inst] = 1'b0;
    check({tag, " vld drop"}, {31'd0, ovld[inst]}, 32'd0);
  endtask

  task automatic random_group(input int inst, input int nterms, input int gidx);
    real sum;
    real t;
    sum     = rand_half();
    bias    = to_fp32(sum);
    relu_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < nterms; i++) begin
      t   = rand_half();
      sum = sum + t;
      send(inst, to_fp32(t));
      tick($urandom_range(0, 3));
    end
    take(inst, $sformatf("rand%0d_%0d", inst, gidx), model(sum, relu_en));
  endtask

  initial begin
    rst_n   = 1'b0;
    vld     = '0;
    rdy     = '0;
    in_data = '0;
    bias    = '0;
    relu_en = 1'b0;
    tick(3);
    check("reset out_vld", {31'd0, ovld[0]}, 32'd0);
    check("reset out_data", odata[0], 32'd0);
    check("reset in_afull", {31'd0, afull[0]}, 32'd0);
    check("reset ovf_err", {31'd0, ovf[0]}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] directed groups");
    bias = 32'h3F00_0000;
    relu_en = 1'b0;
    send(0, 32'h3F80_0000); send(0, 32'h4000_0000); send(0, 32'h4040_0000);
    take(0, "sum_bias", 32'h40D0_0000);

    bias = 32'hC100_0000;
    relu_en = 1'b1;
    send(0, 32'h3F80_0000); send(0, 32'h4000_0000); send(0, 32'h4040_0000);
    take(0, "relu_neg", 32'h0000_0000);

    relu_en = 1'b0;
    send(0, 32'h3F80_0000); send(0, 32'h4000_0000); send(0, 32'h4040_0000);
    take(0, "neg_sum", 32'hC000_0000);

    $display("[TB] back-to-back with stall");
    bias = 32'h0;
    for (int g = 0; g < 2; g++) begin
      send(0, 32'h3F80_0000); send(0, 32'h4000_0000); send(0, 32'h4040_0000);
    end
    wait_out(0, "b2b first");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b stall data %0d", k), odata[0], 32'h40C0_0000);
      check($sformatf("b2b stall vld %0d", k), {31'd0, ovld[0]}, 32'd1);
      tick(5);
    end
    take(0, "b2b g0", 32'h40C0_0000);
    take(0, "b2b g1", 32'h40C0_0000);

    $display("[TB] mid-group reset");
    send(0, 32'h4000_0000); send(0, 32'h4000_0000);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("rst out_vld", {31'd0, ovld[0]}, 32'd0);
    check("rst out_data", odata[0], 32'd0);
    check("rst in_afull", {31'd0, afull[0]}, 32'd0);
    check("rst ovf_err", {31'd0, ovf[0]}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check("rst no output", {31'd0, ovld[0]}, 32'd0);
    send(0, 32'h3F80_0000); send(0, 32'h3F80_0000); send(0, 32'h3F80_0000);
    take(0, "after_rst", 32'h4040_0000);

    $display("[TB] random groups");
    for (int g = 0; g < 8; g++) random_group(0, 3, g);

    $display("[TB] single-term groups");
    bias = 32'h0;
    relu_en = 1'b0;
    send(2, 32'h4080_0000);
    take(2, "single", 32'h4080_0000);
    for (int g = 0; g < 4; g++) random_group(2, 1, g);

    $display("[TB] overflow");
    bias = 32'h3F80_0000;
    relu_en = 1'b0;
    send(1, 32'h4000_0000); send(1, 32'h4000_0000); send(1, 32'h4000_0000);
    wait_out(1, "ovf grp");
    tick(2);
    check("ovf afull empty", {31'd0, afull[1]}, 32'd0);
    send(1, 32'h3F80_0000); send(1, 32'h4000_0000); send(1, 32'h4040_0000);
    check("afull lag", {31'd0, afull[1]}, 32'd0);
    tick(1);
    check("afull rise", {31'd0, afull[1]}, 32'd1);
    send(1, 32'h4080_0000);
    check("ovf before drop", {31'd0, ovf[1]}, 32'd0);
    send(1, 32'h40A0_0000);
    check("ovf set", {31'd0, ovf[1]}, 32'd1);
    tick(5);
    check("ovf sticky", {31'd0, ovf[1]}, 32'd1);
    check("ovf held data", odata[1], 32'h40E0_0000);
    bias = 32'h3F00_0000;
    take(1, "ovf g0", 32'h40E0_0000);
    take(1, "ovf g1", 32'h40D0_0000);
    check("ovf still sticky", {31'd0, ovf[1]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
